student_fir_driver: RTL and testbench
=====================================

// Module: student_fir_driver
// PURPOSE
//  Transmit side of the FIR slice strobe protocol. Accepts samples from an upstream
//  valid/ready stream and issues them to one student FIR slice as single-cycle strobes.
//  Waits for the slice's done pulse, captures the 2*DATA_SIZE sum, then shifts and
//  saturates it. Presents the result on a downstream valid/ready stream.
//  Sits between the audio sample source and the FIR array; a timeout guards against a hung slice.
// PARAMETERS
//  DATA_SIZE      16    sample / result width (bits)
//  OUT_SHIFT      15    arithmetic right shift applied to the FIR sum before saturation
//  TIMEOUT_CYCLES 4096  max cycles in WAIT before abort (must exceed 2**ADDR_WIDTH+8)
// PORTS
//  clk_i                  in   1            clock
//  rst_ni                 in   1            asynchronous reset, active-low
//  s_valid_i              in   1            upstream sample valid
//  s_data_i               in   DATA_SIZE    upstream sample
//  s_ready_o              out  1            upstream ready
//  fir_sample_o           out  DATA_SIZE    sample to FIR slice (held stable until next launch)
//  fir_valid_strobe_o     out  1            launch strobe to FIR slice, 1-cycle pulse
//  fir_valid_strobe_i     in   1            FIR result-valid pulse
//  fir_compute_finished_i in   1            FIR compute-finished pulse
//  fir_y_i                in   2*DATA_SIZE  FIR accumulated sum, two's complement
//  fir_shift_i            in   DATA_SIZE    FIR oldest-sample shift-out
//  m_valid_o              out  1            result valid
//  m_data_o               out  DATA_SIZE    saturated result
//  m_shift_o              out  DATA_SIZE    fir_shift_i captured with the result
//  m_ready_i              in   1            downstream ready
//  busy_o                 out  1            state != IDLE
//  timeout_err_o          out  1            sticky timeout flag
//  clear_err_i            in   1            clears timeout_err_o (1-cycle pulse)
// BEHAVIOUR
//  Reset values: all outputs 0; state = IDLE; timeout counter = 0.
//  FSM states and transitions:
//   IDLE:   s_ready_o = !m_valid_o || m_ready_i.
//           On s_valid_i && s_ready_o: latch s_data_i into fir_sample_o; go to STROBE.
//   STROBE: fir_valid_strobe_o = 1 for exactly this cycle; clear timeout counter; go to WAIT.
//   WAIT:   strobe low; counter increments each cycle.
//           If fir_valid_strobe_i && fir_compute_finished_i: capture the result; go to IDLE.
//           Else if counter == TIMEOUT_CYCLES-1: set timeout_err_o; drop the sample; go to IDLE.
//  Strobe spacing: at least 2 low cycles between strobes, so the slice's edge detector always sees a rising edge.
//  Capture: t = fir_y_i >>> OUT_SHIFT (signed).
//   t > 2**(DATA_SIZE-1)-1 -> m_data_o = 0x7FFF (for DATA_SIZE=16).
//   t < -2**(DATA_SIZE-1)  -> m_data_o = 0x8000.
//   Otherwise m_data_o = t[DATA_SIZE-1:0].
//   m_shift_o <= fir_shift_i. m_valid_o goes high on the edge after done is seen.
//  Output register: m_valid_o falls on m_valid_o && m_ready_i, unless a new capture occurs in the same cycle (capture wins).
//  Upstream acceptance and downstream consumption in the same cycle are legal.
//  m_data_o and m_shift_o stay stable while m_valid_o && !m_ready_i.
//  Done pulses in IDLE or STROBE are ignored.
//  clear_err_i in the same cycle as a new timeout: the flag stays set.
//  Async reset mid-operation returns to IDLE immediately; any in-flight sample is lost; no strobe glitch on release.
//  Throughput: one sample per (FIR latency + 3) cycles; no internal sample buffering.
// CONFIGURATION
//  STUDENT_FIR_DRIVER_STATS_EN defined: adds ports
//   sample_cnt_o[31:0]  launched strobes
//   sat_cnt_o[31:0]     saturated captures
//   to_cnt_o[15:0]      timeouts
//   All counters wrap and reset to 0.
//  Not defined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  student_fir_pkg: typedef enum logic [1:0] {DRV_IDLE, DRV_STROBE, DRV_WAIT} drv_state_t;
//   function sat_shift(logic signed [2*DATA_SIZE-1:0] y, int sh) returning logic [DATA_SIZE-1:0].
//  No sub-module; the saturation function is shared from the package.
// TESTING
//  1 Reset: assert rst_ni low with s_valid_i=1 -> all outputs 0; no strobe until 1 cycle after release + accept.
//  2 Single sample: s_data_i=0x0100; FIR model returns y=0x0000_8000 after 20 cycles.
//    -> exactly one strobe pulse; m_data_o=0x0001 (OUT_SHIFT=15); m_valid_o 1 cycle after done.
//  3 Saturation: y=0x7FFF_FFFF -> m_data_o=0x7FFF; y=0x8000_0000 -> m_data_o=0x8000 (sat_cnt_o += 2 with stats).
//  4 Back-pressure: hold m_ready_i=0 with a result pending.
//    -> s_ready_o=0, no new strobe, m_data_o stable; release -> next sample launched the same cycle.
//  5 Timeout: FIR model never answers -> timeout_err_o=1 after TIMEOUT_CYCLES in WAIT; FSM returns to IDLE.
//    clear_err_i pulse -> flag 0; next sample completes normally.
//  6 Streaming: 64 back-to-back samples, m_ready_i random 50% -> 64 results in order, each matching the reference model.
//    Strobes always separated by at least 2 low cycles.

Source files
------------

// File: rtl/student_fir_pkg.sv
// rtl/student_fir_pkg.sv - shared types and shift/saturate helper for the FIR slice driver
package student_fir_pkg;

    localparam int SF_DATA_SIZE = 16;

    typedef enum logic [1:0] {
        DRV_IDLE,
        DRV_STROBE,
        DRV_WAIT
    } drv_state_t;

    // Arithmetic shift of the wide accumulator, clamped to the signed sample range
    function automatic logic [SF_DATA_SIZE-1:0] sat_shift(
        input logic signed [2*SF_DATA_SIZE-1:0] y,
        input int                               sh
    );
        logic signed [2*SF_DATA_SIZE-1:0] t;
        logic signed [2*SF_DATA_SIZE-1:0] sat_max;
        logic signed [2*SF_DATA_SIZE-1:0] sat_min;
        sat_max = {{(SF_DATA_SIZE+1){1'b0}}, {(SF_DATA_SIZE-1){1'b1}}};
        sat_min = {{(SF_DATA_SIZE+1){1'b1}}, {(SF_DATA_SIZE-1){1'b0}}};
        t = y >>> sh;
        if (t > sat_max) begin
            return {1'b0, {(SF_DATA_SIZE-1){1'b1}}};
        end else if (t < sat_min) begin
            return {1'b1, {(SF_DATA_SIZE-1){1'b0}}};
        end
        return t[SF_DATA_SIZE-1:0];
    endfunction

endpackage

// File: rtl/student_fir_driver.sv
// rtl/student_fir_driver.sv - strobe-protocol driver for one FIR slice with result capture and timeout
// Optional statistics counters enabled by STUDENT_FIR_DRIVER_STATS_EN.
module student_fir_driver
    import student_fir_pkg::*;
#(
    parameter int DATA_SIZE      = SF_DATA_SIZE,
    parameter int OUT_SHIFT      = 15,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   s_valid_i,
    input  logic [DATA_SIZE-1:0]   s_data_i,
    output logic                   s_ready_o,
    output logic [DATA_SIZE-1:0]   fir_sample_o,
    output logic                   fir_valid_strobe_o,
    input  logic                   fir_valid_strobe_i,
    input  logic                   fir_compute_finished_i,
    input  logic [2*DATA_SIZE-1:0] fir_y_i,
    input  logic [DATA_SIZE-1:0]   fir_shift_i,
    output logic                   m_valid_o,
    output logic [DATA_SIZE-1:0]   m_data_o,
    output logic [DATA_SIZE-1:0]   m_shift_o,
    input  logic                   m_ready_i,
    output logic                   busy_o,
    output logic                   timeout_err_o,
    input  logic                   clear_err_i
`ifdef STUDENT_FIR_DRIVER_STATS_EN
    ,
    output logic [31:0]            sample_cnt_o,
    output logic [31:0]            sat_cnt_o,
    output logic [15:0]            to_cnt_o
`endif
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    drv_state_t             r_state;
    drv_state_t             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [DATA_SIZE-1:0]   r_sample;
    logic                   r_m_valid;
    logic [DATA_SIZE-1:0]   r_m_data;
    logic [DATA_SIZE-1:0]   r_m_shift;
    logic                   r_err;
    logic                   w_done;
    logic                   w_cnt_last;
    logic                   w_capture;
    logic                   w_timeout;
    logic                   w_accept;

    assign w_done     = fir_valid_strobe_i && fir_compute_finished_i;
    assign w_cnt_last = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_capture  = (r_state == DRV_WAIT) && w_done;
    assign w_timeout  = (r_state == DRV_WAIT) && !w_done && w_cnt_last;
    assign w_accept   = s_valid_i && s_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= DRV_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            DRV_IDLE:   if (w_accept) w_state_nxt = DRV_STROBE;
            DRV_STROBE: w_state_nxt = DRV_WAIT;
            DRV_WAIT:   if (w_capture || w_timeout) w_state_nxt = DRV_IDLE;
            default:    w_state_nxt = DRV_IDLE;
        endcase
    end

    // Ready is gated by reset so every output reads 0 while held in reset
    always_comb begin
        s_ready_o          = 1'b0;
        fir_valid_strobe_o = 1'b0;
        busy_o             = (r_state != DRV_IDLE);
        case (r_state)
            DRV_IDLE:   s_ready_o = rst_ni && (!r_m_valid || m_ready_i);
            DRV_STROBE: fir_valid_strobe_o = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sample  <= '0;
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_shift <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sample <= s_data_i;
            end
            if (r_state == DRV_STROBE) begin
                r_cnt <= '0;
            end else if (r_state == DRV_WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // A fresh capture overrides the downstream pop in the same cycle
            if (w_capture) begin
                r_m_valid <= 1'b1;
                r_m_data  <= sat_shift(fir_y_i, OUT_SHIFT);
                r_m_shift <= fir_shift_i;
            end else if (r_m_valid && m_ready_i) begin
                r_m_valid <= 1'b0;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end else if (clear_err_i) begin
                r_err <= 1'b0;
            end
        end
    end

    assign fir_sample_o  = r_sample;
    assign m_valid_o     = r_m_valid;
    assign m_data_o      = r_m_data;
    assign m_shift_o     = r_m_shift;
    assign timeout_err_o = r_err;

`ifdef STUDENT_FIR_DRIVER_STATS_EN
    logic signed [2*DATA_SIZE-1:0] w_shifted;
    logic                          w_sat;
    logic [31:0]                   r_sample_cnt;
    logic [31:0]                   r_sat_cnt;
    logic [15:0]                   r_to_cnt;

    // Saturation occurs when the bits above the sign position are not all equal
    assign w_shifted = $signed(fir_y_i) >>> OUT_SHIFT;
    assign w_sat     = !(&w_shifted[2*DATA_SIZE-1:DATA_SIZE-1])
                    && (|w_shifted[2*DATA_SIZE-1:DATA_SIZE-1]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sample_cnt <= '0;
            r_sat_cnt    <= '0;
            r_to_cnt     <= '0;
        end else begin
            if (r_state == DRV_STROBE) r_sample_cnt <= r_sample_cnt + 32'd1;
            if (w_capture && w_sat)    r_sat_cnt    <= r_sat_cnt + 32'd1;
            if (w_timeout)             r_to_cnt     <= r_to_cnt + 16'd1;
        end
    end

    assign sample_cnt_o = r_sample_cnt;
    assign sat_cnt_o    = r_sat_cnt;
    assign to_cnt_o     = r_to_cnt;
`endif

endmodule

// File: tb/tb_student_fir_driver.sv
// tb/tb_student_fir_driver.sv - directed/table-driven bench for student_fir_driver with a FIR slice model
module tb_student_fir_driver;

    localparam int DW = 16;
    localparam int TO = 4096;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          s_valid_i = 1'b0;
    logic [DW-1:0] s_data_i = '0;
    logic          s_ready_o;
    logic [DW-1:0] fir_sample_o;
    logic          fir_valid_strobe_o;
    logic          fir_valid_strobe_i = 1'b0;
    logic          fir_compute_finished_i = 1'b0;
    logic [2*DW-1:0] fir_y_i = '0;
    logic [DW-1:0] fir_shift_i = '0;
    logic          m_valid_o;
    logic [DW-1:0] m_data_o;
    logic [DW-1:0] m_shift_o;
    logic          m_ready_i = 1'b0;
    logic          busy_o;
    logic          timeout_err_o;
    logic          clear_err_i = 1'b0;
`ifdef STUDENT_FIR_DRIVER_STATS_EN
    logic [31:0]   sample_cnt_o;
    logic [31:0]   sat_cnt_o;
    logic [15:0]   to_cnt_o;
`endif

    student_fir_driver #(.DATA_SIZE(DW), .OUT_SHIFT(15), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
        .fir_sample_o(fir_sample_o), .fir_valid_strobe_o(fir_valid_strobe_o),
        .fir_valid_strobe_i(fir_valid_strobe_i), .fir_compute_finished_i(fir_compute_finished_i),
        .fir_y_i(fir_y_i), .fir_shift_i(fir_shift_i),
        .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_shift_o(m_shift_o), .m_ready_i(m_ready_i),
        .busy_o(busy_o), .timeout_err_o(timeout_err_o), .clear_err_i(clear_err_i)
`ifdef STUDENT_FIR_DRIVER_STATS_EN
        , .sample_cnt_o(sample_cnt_o), .sat_cnt_o(sat_cnt_o), .to_cnt_o(to_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // FIR slice model: answers each strobe after a latency with a done pulse
    int          resp_lat = 20;
    logic [31:0] resp_y = '0;
    logic [15:0] resp_shift = '0;
    bit          resp_hang = 1'b0;
    bit          resp_mode = 1'b0;
    int          inject_cnt = 0;
    int          inject_seen = 0;
    int          done_cyc = -100;
    int          pend = 0;
    int          strobes = 0;
    int          last_strobe = -100;
    int          gap_err = 0;

    always @(negedge clk_i) begin
        fir_valid_strobe_i     = 1'b0;
        fir_compute_finished_i = 1'b0;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) begin
                fir_valid_strobe_i     = 1'b1;
                fir_compute_finished_i = 1'b1;
                fir_y_i     = resp_mode ? {fir_sample_o, 16'h0000} : resp_y;
                fir_shift_i = resp_mode ? ~fir_sample_o : resp_shift;
                done_cyc    = cyc;
            end
        end
        if (inject_cnt != inject_seen) begin
            inject_seen            = inject_cnt;
            fir_valid_strobe_i     = 1'b1;
            fir_compute_finished_i = 1'b1;
            fir_y_i                = 32'h1234_0000;
        end
        if (fir_valid_strobe_o) begin
            strobes = strobes + 1;
            if (cyc - last_strobe < 3) gap_err = gap_err + 1;
            last_strobe = cyc;
            if (!resp_hang) pend = resp_mode ? $urandom_range(1, 6) : resp_lat;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [15:0] smp);
        bit ok;
        ok = 1'b0;
        s_valid_i = 1'b1;
        s_data_i  = smp;
        for (int k = 0; k < 200 && !ok; k++) begin
            #1;
            if (s_ready_o) ok = 1'b1;
            @(negedge clk_i);
        end
        s_valid_i = 1'b0;
        chk("launch_accept", 32'(ok), 32'd1);
        chk("launch_strobe", 32'(fir_valid_strobe_o), 32'd1);
        chk("launch_sample", 32'(fir_sample_o), 32'(smp));
    endtask

    task automatic wait_valid(input int bound, output int vcyc);
        vcyc = -1;
        for (int k = 0; k < bound && vcyc < 0; k++) begin
            if (m_valid_o) vcyc = cyc;
            else @(negedge clk_i);
        end
        chk("wait_valid", 32'(vcyc >= 0), 32'd1);
    endtask

    task automatic consume();
        m_ready_i = 1'b1;
        @(negedge clk_i);
        m_ready_i = 1'b0;
        chk("consume_valid_low", 32'(m_valid_o), 32'd0);
    endtask

    function automatic logic [15:0] ref_out(input logic [15:0] s);
        longint v;
        v = 2 * longint'($signed(s));
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        return v[15:0];
    endfunction

    typedef struct {
        logic [15:0] sample;
        logic [31:0] y;
        logic [15:0] shift;
        int          lat;
        logic [15:0] exp_d;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic [15:0] sh;
    } res_t;

    vec_t vecs[9];
    res_t exp_q[$];
    logic [15:0] samp[64];

    initial begin
        int vc, s0, sent, rcvd, guard;
        bit acc;
        res_t r;

        vecs[0] = '{16'h0100, 32'h0000_8000, 16'hA5A5, 20, 16'h0001};
        vecs[1] = '{16'h0001, 32'h7FFF_FFFF, 16'h0001, 3,  16'h7FFF};
        vecs[2] = '{16'h0002, 32'h8000_0000, 16'h0002, 3,  16'h8000};
        vecs[3] = '{16'h0003, 32'h3FFF_8000, 16'h1111, 1,  16'h7FFF};
        vecs[4] = '{16'h0004, 32'h4000_0000, 16'h2222, 2,  16'h7FFF};
        vecs[5] = '{16'h0005, 32'hC000_0000, 16'h3333, 5,  16'h8000};
        vecs[6] = '{16'h0006, 32'hBFFF_8000, 16'h4444, 4,  16'h8000};
        vecs[7] = '{16'h0007, 32'hFFFF_FFFF, 16'h5555, 1,  16'hFFFF};
        vecs[8] = '{16'h0008, 32'h0012_3456, 16'h6666, 7,  16'h0024};

        // Reset with upstream valid asserted
        s_valid_i = 1'b1;
        s_data_i  = 16'h1234;
        repeat (3) @(negedge clk_i);
        chk("rst_s_ready", 32'(s_ready_o), 32'd0);
        chk("rst_strobe", 32'(fir_valid_strobe_o), 32'd0);
        chk("rst_m_valid", 32'(m_valid_o), 32'd0);
        chk("rst_m_data", 32'(m_data_o), 32'd0);
        chk("rst_m_shift", 32'(m_shift_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_err", 32'(timeout_err_o), 32'd0);
        chk("rst_sample", 32'(fir_sample_o), 32'd0);
        rst_ni = 1'b1;
        #1;
        chk("release_no_strobe", 32'(fir_valid_strobe_o), 32'd0);
        @(negedge clk_i);
        s_valid_i = 1'b0;
        chk("release_strobe", 32'(fir_valid_strobe_o), 32'd1);
        chk("release_sample", 32'(fir_sample_o), 32'h1234);
        @(negedge clk_i);
        chk("strobe_one_cycle", 32'(fir_valid_strobe_o), 32'd0);
        wait_valid(60, vc);
        consume();

        // Table of single transactions, incl. saturation boundaries
        for (int i = 0; i < 9; i++) begin
            resp_y     = vecs[i].y;
            resp_shift = vecs[i].shift;
            resp_lat   = vecs[i].lat;
            s0 = strobes;
            launch(vecs[i].sample);
            wait_valid(vecs[i].lat + 10, vc);
            chk($sformatf("vec%0d_lat", i), 32'(vc), 32'(done_cyc + 1));
            chk($sformatf("vec%0d_data", i), 32'(m_data_o), 32'(vecs[i].exp_d));
            chk($sformatf("vec%0d_shift", i), 32'(m_shift_o), 32'(vecs[i].shift));
            chk($sformatf("vec%0d_strobes", i), 32'(strobes - s0), 32'd1);
            consume();
        end
`ifdef STUDENT_FIR_DRIVER_STATS_EN
        chk("stats_sat", sat_cnt_o, 32'd4);
        chk("stats_samples", sample_cnt_o, 32'd10);
`endif

        // Back-pressure with a result pending
        resp_y = 32'h0002_0000; resp_shift = 16'hBEEF; resp_lat = 3;
        launch(16'h0AAA);
        wait_valid(20, vc);
        s0 = strobes;
        s_valid_i = 1'b1;
        s_data_i  = 16'h0BBB;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            #1;
            chk("bp_s_ready", 32'(s_ready_o), 32'd0);
            chk("bp_data_stable", 32'(m_data_o), 32'h0004);
        end
        chk("bp_no_strobe", 32'(strobes - s0), 32'd0);
        m_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", 32'(s_ready_o), 32'd1);
        @(negedge clk_i);
        m_ready_i = 1'b0;
        s_valid_i = 1'b0;
        chk("bp_release_strobe", 32'(fir_valid_strobe_o), 32'd1);
        chk("bp_release_valid", 32'(m_valid_o), 32'd0);
        chk("bp_release_sample", 32'(fir_sample_o), 32'h0BBB);
        wait_valid(20, vc);
        chk("bp_second_data", 32'(m_data_o), 32'h0004);
        consume();

        // Timeout: model never answers
        resp_hang = 1'b1;
        launch(16'h0CCC);
        repeat (TO) @(negedge clk_i);
        chk("to_not_early", 32'(timeout_err_o), 32'd0);
        chk("to_busy_before", 32'(busy_o), 32'd1);
        @(negedge clk_i);
        chk("to_flag", 32'(timeout_err_o), 32'd1);
        chk("to_idle", 32'(busy_o), 32'd0);
        chk("to_no_result", 32'(m_valid_o), 32'd0);
        inject_cnt++;
        repeat (3) @(negedge clk_i);
        chk("idle_done_ignored", 32'(m_valid_o), 32'd0);
        chk("idle_done_busy", 32'(busy_o), 32'd0);
        clear_err_i = 1'b1;
        @(negedge clk_i);
        clear_err_i = 1'b0;
        chk("to_cleared", 32'(timeout_err_o), 32'd0);
        launch(16'h0DDD);
        repeat (TO) @(negedge clk_i);
        clear_err_i = 1'b1;
        @(negedge clk_i);
        clear_err_i = 1'b0;
        chk("to_clear_same_cycle", 32'(timeout_err_o), 32'd1);
        clear_err_i = 1'b1;
        @(negedge clk_i);
        clear_err_i = 1'b0;
        chk("to_cleared2", 32'(timeout_err_o), 32'd0);
`ifdef STUDENT_FIR_DRIVER_STATS_EN
        chk("stats_to", 32'(to_cnt_o), 32'd2);
`endif
        resp_hang = 1'b0;
        resp_y = 32'hFFFF_0000; resp_shift = 16'h0F0F; resp_lat = 4;
        launch(16'h0EEE);
        wait_valid(20, vc);
        chk("after_to_data", 32'(m_data_o), 32'hFFFE);
        chk("after_to_shift", 32'(m_shift_o), 32'h0F0F);
        consume();

        // Streaming with random downstream ready
        samp[0] = 16'h7FFF; samp[1] = 16'h8000; samp[2] = 16'h0000;
        samp[3] = 16'h3FFF; samp[4] = 16'h4000; samp[5] = 16'hC000;
        for (int i = 6; i < 64; i++) samp[i] = 16'($urandom);
        resp_mode = 1'b1;
        sent = 0; rcvd = 0; guard = 0;
        s_valid_i = 1'b1;
        s_data_i  = samp[0];
        while (rcvd < 64 && guard < 5000) begin
            m_ready_i = 1'($urandom_range(0, 1));
            #1;
            if (m_valid_o && m_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("stream_unexpected", 32'd1, 32'd0);
                end else begin
                    r = exp_q.pop_front();
                    chk($sformatf("stream%0d_data", rcvd), 32'(m_data_o), 32'(r.d));
                    chk($sformatf("stream%0d_shift", rcvd), 32'(m_shift_o), 32'(r.sh));
                end
                rcvd++;
            end
            acc = s_valid_i && s_ready_o;
            if (acc) begin
                r.d  = ref_out(samp[sent]);
                r.sh = ~samp[sent];
                exp_q.push_back(r);
                sent++;
            end
            @(negedge clk_i);
            if (acc) begin
                if (sent < 64) s_data_i = samp[sent];
                else s_valid_i = 1'b0;
            end
            guard++;
        end
        s_valid_i = 1'b0;
        m_ready_i = 1'b0;
        chk("stream_count", 32'(rcvd), 32'd64);
        chk("strobe_gap", 32'(gap_err), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
